// File: rtl/bnn_fc_scheduler.sv
// Sequences one binary fully-connected layer over the shared xnor_popcount datapath:
// issues chunk reads per neuron, accumulates returned popcounts, presents each neuron result.
module bnn_fc_scheduler #(
  parameter int WL      = 112,
  parameter int N_CHUNK = 4,
  parameter int N_OUT   = 10,
  parameter int RD_LAT  = 1,
  parameter int ACC_W   = 11,
  parameter int WA_W    = 8,
  localparam int XA_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [ACC_W-1:0] iTHRESH,
  output logic             oRD_EN,
  output logic [WA_W-1:0]  oWADDR,
  output logic [XA_W-1:0]  oXADDR,
  output logic             oPC_EN,
  input  logic             iPC_VALID,
  input  logic [ACC_W-1:0] iPC_DATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [IDX_W-1:0] oIDX,
  output logic [ACC_W-1:0] oSUM,
  output logic [ACC_W:0]   oSCORE,
  output logic             oBIT,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam int RC_W   = $clog2(N_CHUNK + 1);
  localparam int TOT_I  = WL * N_CHUNK;
  localparam int LC_I   = N_CHUNK - 1;
  localparam int LN_I   = N_OUT - 1;
  localparam int RF_I   = N_CHUNK;
  localparam logic [ACC_W:0]   TOTAL       = TOT_I[ACC_W:0];
  localparam logic [XA_W-1:0]  LAST_CHUNK  = LC_I[XA_W-1:0];
  localparam logic [IDX_W-1:0] LAST_NEURON = LN_I[IDX_W-1:0];
  localparam logic [RC_W-1:0]  RC_FULL     = RF_I[RC_W-1:0];

  generate
    if (WL * N_CHUNK > (2 ** ACC_W) - 1) begin : g_acc_chk
      $error("ACC_W too narrow for WL*N_CHUNK");
    end
    if (N_OUT * N_CHUNK > (2 ** WA_W)) begin : g_wa_chk
      $error("WA_W too narrow for N_OUT*N_CHUNK");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_thresh;
  logic [IDX_W-1:0]   r_neuron;
  logic [XA_W-1:0]    r_chunk;
  logic [RC_W-1:0]    r_ret;
  logic [ACC_W-1:0]   r_acc;
  logic               r_rd_en;
  logic [WA_W-1:0]    r_waddr;
  logic [RD_LAT-1:0]  r_pc_pipe;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [ACC_W-1:0]   r_sum;
  logic [ACC_W:0]     r_score;
  logic               r_bit;
  logic               r_busy;
  logic               r_done;

  // Returns are only counted while a neuron is in flight; strays elsewhere are dropped.
  logic               w_take;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [RC_W-1:0]    w_ret_nxt;
  logic [ACC_W:0]     w_score;

  assign w_take    = iPC_VALID && (r_state == S_ISSUE || r_state == S_WAIT);
  assign w_acc_nxt = r_acc + (w_take ? iPC_DATA : '0);
  assign w_ret_nxt = r_ret + RC_W'(w_take);
  assign w_score   = {w_acc_nxt, 1'b0} - TOTAL;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_thresh  <= '0;
      r_neuron  <= '0;
      r_chunk   <= '0;
      r_ret     <= '0;
      r_acc     <= '0;
      r_rd_en   <= 1'b0;
      r_waddr   <= '0;
      r_pc_pipe <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_score   <= '0;
      r_bit     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pc_pipe[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_pc_pipe[i] <= r_pc_pipe[i-1];
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iSTART) begin
            r_thresh <= iTHRESH;
            r_neuron <= '0;
            r_waddr  <= '0;
            r_chunk  <= '0;
            r_acc    <= '0;
            r_ret    <= '0;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_acc   <= w_acc_nxt;
          r_ret   <= w_ret_nxt;
          // Address keeps running so it lands on the next neuron's base.
          r_waddr <= r_waddr + WA_W'(1);
          if (r_chunk == LAST_CHUNK) begin
            r_chunk <= '0;
            r_rd_en <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_chunk <= r_chunk + XA_W'(1);
          end
        end
        S_WAIT: begin
          r_acc <= w_acc_nxt;
          r_ret <= w_ret_nxt;
          if (w_ret_nxt >= RC_FULL) begin
            r_valid <= 1'b1;
            r_idx   <= r_neuron;
            r_sum   <= w_acc_nxt;
            r_score <= w_score;
            r_bit   <= (w_acc_nxt >= r_thresh);
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (iREADY) begin
            r_valid <= 1'b0;
            if (r_neuron == LAST_NEURON) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_neuron <= r_neuron + IDX_W'(1);
              r_acc    <= '0;
              r_ret    <= '0;
              r_rd_en  <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oRD_EN = r_rd_en;
  assign oWADDR = r_waddr;
  assign oXADDR = r_chunk;
  assign oPC_EN = r_pc_pipe[RD_LAT-1];
  assign oVALID = r_valid;
  assign oIDX   = r_idx;
  assign oSUM   = r_sum;
  assign oSCORE = r_score;
  assign oBIT   = r_bit;
  assign oBUSY  = r_busy;
  assign oDONE  = r_done;

endmodule
